// File: rtl/mqcr_rect_scheduler.sv
//==============================================================================
// Module  : mqcr_rect_scheduler
// Brief   : Reads a rectangle out of the accumulator image in row-major order
//           and streams it to the quantizer through a 2-entry output buffer.
//           Optional start-offset range check: SCHED_BOUNDS_CHECK_EN.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package pkg_parameters;
    localparam int FEATURE_MAP_RESOLUTION = 8;
    localparam int FEATURE_MAP_ADDRWIDE   = 9;
endpackage

module mqcr_rect_scheduler
    import pkg_parameters::*;
#(
    parameter int IMG_W        = 35,
    parameter int IMG_H        = 35,
    parameter int REC_IMG_W    = 29,
    parameter int REC_IMG_H    = 13,
    parameter int ACC_ADDRWIDE = 11
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic                                    start_i,
    input  logic [5:0]                              row_off_i,
    input  logic [5:0]                              col_off_i,
    output logic                                    busy_o,
    output logic                                    done_o,
    output logic                                    err_o,
    output logic                                    acc_rd_en_o,
    output logic [ACC_ADDRWIDE-1:0]                 acc_rd_addr_o,
    input  logic signed [2*FEATURE_MAP_RESOLUTION-1:0] acc_rd_data_i,
    output logic                                    sched_valid_o,
    output logic signed [2*FEATURE_MAP_RESOLUTION-1:0] sched_data_o,
    output logic [FEATURE_MAP_ADDRWIDE-1:0]         sched_addr_o,
    input  logic                                    sched_ready_i
);

    localparam int c_DW = 2 * FEATURE_MAP_RESOLUTION;
    localparam int c_AW = FEATURE_MAP_ADDRWIDE;
    localparam int c_RW = (REC_IMG_H > 1) ? $clog2(REC_IMG_H) : 1;
    localparam int c_CW = (REC_IMG_W > 1) ? $clog2(REC_IMG_W) : 1;
    localparam logic [c_CW-1:0] c_C_LAST   = c_CW'(REC_IMG_W - 1);
    localparam logic [c_AW-1:0] c_IDX_LAST = c_AW'(REC_IMG_W * REC_IMG_H - 1);

    if (REC_IMG_H > IMG_H || REC_IMG_W > IMG_W) begin : g_cfg_check
        $error("mqcr_rect_scheduler: rectangle larger than accumulator image");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [5:0]              row_off_q, row_off_d, col_off_q, col_off_d;
    logic [c_RW-1:0]         r_q, r_d;
    logic [c_CW-1:0]         c_q, c_d;
    logic [c_AW-1:0]         idx_q, idx_d;
    logic                    infl_q, infl_d;
    logic [c_AW-1:0]         infl_addr_q, infl_addr_d;
    logic [1:0]              cnt_q, cnt_d;
    logic signed [c_DW-1:0]  head_data_q, head_data_d, tail_data_q, tail_data_d;
    logic [c_AW-1:0]         head_addr_q, head_addr_d, tail_addr_q, tail_addr_d;

    logic w_pop, w_room, w_rd_en, w_start_ok;

`ifdef SCHED_BOUNDS_CHECK_EN
    logic err_q, err_d;
    logic w_oob;
    assign w_oob = (32'(row_off_i) > 32'(IMG_H - REC_IMG_H)) ||
                   (32'(col_off_i) > 32'(IMG_W - REC_IMG_W));
    assign w_start_ok = start_i && !w_oob;
    assign err_d      = (state_q == S_IDLE) && start_i && w_oob;
    assign err_o      = err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) err_q <= 1'b0;
        else       err_q <= err_d;
    end
`else
    assign w_start_ok = start_i;
    assign err_o      = 1'b0;
`endif

    // A read may only issue if its data is guaranteed a free buffer slot on arrival.
    assign w_pop   = (cnt_q != 2'd0) && sched_ready_i;
    assign w_room  = ({1'b0, cnt_q} + {2'b00, infl_q}) <= (3'd1 + {2'b00, w_pop});
    assign w_rd_en = (state_q == S_RUN) && w_room;

    assign acc_rd_en_o   = w_rd_en;
    assign acc_rd_addr_o = ACC_ADDRWIDE'((32'(row_off_q) + 32'(r_q)) * 32'(IMG_W)
                                         + 32'(col_off_q) + 32'(c_q));
    assign busy_o        = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done_o        = (state_q == S_DONE);
    assign sched_valid_o = (cnt_q != 2'd0);
    assign sched_data_o  = head_data_q;
    assign sched_addr_o  = head_addr_q;

    always_comb begin
        state_d     = state_q;
        row_off_d   = row_off_q;
        col_off_d   = col_off_q;
        r_d         = r_q;
        c_d         = c_q;
        idx_d       = idx_q;
        infl_d      = w_rd_en;
        infl_addr_d = idx_q;
        cnt_d       = cnt_q;
        head_data_d = head_data_q;
        head_addr_d = head_addr_q;
        tail_data_d = tail_data_q;
        tail_addr_d = tail_addr_q;

        unique case (state_q)
            S_IDLE: begin
                if (w_start_ok) begin
                    state_d   = S_RUN;
                    row_off_d = row_off_i;
                    col_off_d = col_off_i;
                    r_d       = '0;
                    c_d       = '0;
                    idx_d     = '0;
                end
            end
            S_RUN: begin
                if (w_rd_en) begin
                    idx_d = idx_q + 1'b1;
                    if (c_q == c_C_LAST) begin
                        c_d = '0;
                        r_d = r_q + 1'b1;
                    end else begin
                        c_d = c_q + 1'b1;
                    end
                    if (idx_q == c_IDX_LAST) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_pop && head_addr_q == c_IDX_LAST) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        // Returning read data (infl_q) is the push side of the buffer.
        if (infl_q && w_pop) begin
            if (cnt_q == 2'd1) begin
                head_data_d = acc_rd_data_i;
                head_addr_d = infl_addr_q;
            end else begin
                head_data_d = tail_data_q;
                head_addr_d = tail_addr_q;
                tail_data_d = acc_rd_data_i;
                tail_addr_d = infl_addr_q;
            end
        end else if (w_pop) begin
            head_data_d = tail_data_q;
            head_addr_d = tail_addr_q;
            cnt_d       = cnt_q - 2'd1;
        end else if (infl_q) begin
            if (cnt_q == 2'd0) begin
                head_data_d = acc_rd_data_i;
                head_addr_d = infl_addr_q;
            end else begin
                tail_data_d = acc_rd_data_i;
                tail_addr_d = infl_addr_q;
            end
            cnt_d = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            row_off_q   <= '0;
            col_off_q   <= '0;
            r_q         <= '0;
            c_q         <= '0;
            idx_q       <= '0;
            infl_q      <= 1'b0;
            infl_addr_q <= '0;
            cnt_q       <= '0;
            head_data_q <= '0;
            head_addr_q <= '0;
            tail_data_q <= '0;
            tail_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            row_off_q   <= row_off_d;
            col_off_q   <= col_off_d;
            r_q         <= r_d;
            c_q         <= c_d;
            idx_q       <= idx_d;
            infl_q      <= infl_d;
            infl_addr_q <= infl_addr_d;
            cnt_q       <= cnt_d;
            head_data_q <= head_data_d;
            head_addr_q <= head_addr_d;
            tail_data_q <= tail_data_d;
            tail_addr_q <= tail_addr_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mqcr_rect_scheduler.sv
//==============================================================================
// Module  : tb_mqcr_rect_scheduler
// Brief   : Self-checking bench: frame table plus abort/stall sequences,
//           checked against a row-major traversal model and memory model.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mqcr_rect_scheduler;
    import pkg_parameters::*;

    localparam int DW  = 2 * FEATURE_MAP_RESOLUTION;
    localparam int IW  = 35;
    localparam int RW  = 29;
    localparam int N   = 29 * 13;

    logic                          clk_i = 1'b0;
    logic                          rst_i;
    logic                          start_i;
    logic [5:0]                    row_off_i, col_off_i;
    logic                          busy_o, done_o, err_o;
    logic                          acc_rd_en_o;
    logic [10:0]                   acc_rd_addr_o;
    logic signed [DW-1:0]          acc_rd_data_i;
    logic                          sched_valid_o;
    logic signed [DW-1:0]          sched_data_o;
    logic [FEATURE_MAP_ADDRWIDE-1:0] sched_addr_o;
    logic                          sched_ready_i;

    int n_cmp = 0;
    int n_err = 0;

    mqcr_rect_scheduler dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .row_off_i     (row_off_i),
        .col_off_i     (col_off_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o),
        .acc_rd_en_o   (acc_rd_en_o),
        .acc_rd_addr_o (acc_rd_addr_o),
        .acc_rd_data_i (acc_rd_data_i),
        .sched_valid_o (sched_valid_o),
        .sched_data_o  (sched_data_o),
        .sched_addr_o  (sched_addr_o),
        .sched_ready_i (sched_ready_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic signed [DW-1:0] mem_f(input int a);
        int v;
        v = (a * 97 + 13) ^ (a << 5);
        return DW'(v);
    endfunction

    function automatic int exp_acc(input int ro, input int co, input int k);
        return (ro + k / RW) * IW + co + k % RW;
    endfunction

    // Accumulator memory: data valid one cycle after the read strobe, junk otherwise.
    always @(posedge clk_i) begin
        if (acc_rd_en_o) acc_rd_data_i <= mem_f(int'(acc_rd_addr_o));
        else             acc_rd_data_i <= DW'($urandom);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  32'(busy_o), 32'd0);
        chk({tag, "_done"},  32'(done_o), 32'd0);
        chk({tag, "_err"},   32'(err_o), 32'd0);
        chk({tag, "_rd_en"}, 32'(acc_rd_en_o), 32'd0);
        chk({tag, "_rd_addr"}, 32'(acc_rd_addr_o), 32'd0);
        chk({tag, "_valid"}, 32'(sched_valid_o), 32'd0);
        chk({tag, "_data"},  32'(sched_data_o), 32'd0);
        chk({tag, "_addr"},  32'(sched_addr_o), 32'd0);
    endtask

    // mode: 0 ready high, 1 ready high 1-of-3 random, 2 ready low until cycle 20
    task automatic run_frame(input int ro, input int co, input int mode, input int again_at,
                             input int abort_at, input bit exp_err,
                             input int exp_first, input int exp_last);
        int reads, hs, dones, last_acc, last_hs_cyc, end_cyc;
        bit pv, pr, fin, exp_busy, exp_done;
        logic [31:0] pd, pa;
        reads = 0; hs = 0; dones = 0; last_acc = -1; last_hs_cyc = -10; end_cyc = -1;
        pv = 1'b0; pr = 1'b1; pd = '0; pa = '0; fin = 1'b0;
        for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
            @(negedge clk_i);
            start_i   = (cyc == 0) || (cyc == again_at);
            row_off_i = (cyc == 0) ? 6'(ro) : 6'($urandom);
            col_off_i = (cyc == 0) ? 6'(co) : 6'($urandom);
            case (mode)
                0:       sched_ready_i = 1'b1;
                1:       sched_ready_i = ($urandom_range(0, 2) == 0);
                default: sched_ready_i = (cyc > 20);
            endcase
            #1;
            if (exp_err) begin
                if (cyc == 1) chk("err_pulse", 32'(err_o), 32'd1);
                if (cyc == 2) chk("err_clear", 32'(err_o), 32'd0);
                if (cyc >= 1) begin
                    chk("err_busy", 32'(busy_o), 32'd0);
                    chk("err_rd_en", 32'(acc_rd_en_o), 32'd0);
                end
                if (cyc == 6) fin = 1'b1;
            end else begin
                exp_busy = (cyc >= 1) && (hs < N);
                exp_done = (cyc == last_hs_cyc + 1);
                chk("busy", 32'(busy_o), 32'(exp_busy));
                chk("done", 32'(done_o), 32'(exp_done));
                if (cyc == 1) begin
                    chk("err_quiet", 32'(err_o), 32'd0);
                    chk("first_rd_cycle", 32'(acc_rd_en_o), 32'd1);
                end
                if (mode == 0 && cyc == 2) chk("valid_cyc2", 32'(sched_valid_o), 32'd0);
                if (mode == 0 && cyc == 3) chk("valid_cyc3", 32'(sched_valid_o), 32'd1);
                chk("occupancy", 32'(reads - hs <= 2), 32'd1);
                if (pv && !pr) begin
                    chk("stall_valid", 32'(sched_valid_o), 32'd1);
                    chk("stall_data", 32'(sched_data_o), pd);
                    chk("stall_addr", 32'(sched_addr_o), pa);
                end
                if (acc_rd_en_o) begin
                    chk("rd_in_range", 32'(reads < N), 32'd1);
                    if (reads == 0) chk("first_acc_addr", 32'(acc_rd_addr_o), 32'(exp_first));
                    chk("acc_addr", 32'(acc_rd_addr_o), 32'(exp_acc(ro, co, reads)));
                    last_acc = int'(acc_rd_addr_o);
                    reads++;
                end
                if (mode == 2 && cyc == 20) chk("stall_reads", 32'(reads), 32'd2);
                if (sched_valid_o && sched_ready_i) begin
                    chk("hs_addr", 32'(sched_addr_o), 32'(hs));
                    chk("hs_data", 32'(sched_data_o), 32'(mem_f(exp_acc(ro, co, hs))));
                    hs++;
                    if (hs == N) last_hs_cyc = cyc;
                end
                if (done_o) begin
                    dones++;
                    if (end_cyc < 0) end_cyc = cyc + 4;
                end
                if (cyc == end_cyc) fin = 1'b1;
                pv = sched_valid_o; pr = sched_ready_i;
                pd = 32'(sched_data_o); pa = 32'(sched_addr_o);
                if (abort_at > 0 && hs == abort_at) begin
                    rst_i = 1'b1; start_i = 1'b0;
                    #1;
                    chk_all_zero("abort");
                    @(negedge clk_i);
                    rst_i = 1'b0;
                    for (int k = 0; k < 6; k++) begin
                        @(negedge clk_i); #1;
                        chk("post_abort_valid", 32'(sched_valid_o), 32'd0);
                        chk("post_abort_rd_en", 32'(acc_rd_en_o), 32'd0);
                        chk("post_abort_done", 32'(done_o), 32'd0);
                        chk("post_abort_busy", 32'(busy_o), 32'd0);
                    end
                    return;
                end
            end
        end
        chk("frame_finished", 32'(fin), 32'd1);
        if (!exp_err) begin
            chk("hs_total", 32'(hs), 32'(N));
            chk("reads_total", 32'(reads), 32'(N));
            chk("last_acc_addr", 32'(last_acc), 32'(exp_last));
            chk("done_count", 32'(dones), 32'd1);
        end
    endtask

    typedef struct {
        int ro;
        int co;
        int mode;
        int again_at;
        bit exp_err;
        int exp_first;
        int exp_last;
    } vec_t;

    vec_t tbl[7];

    initial begin
        tbl[0] = '{ro: 0,  co: 0, mode: 0, again_at: -1, exp_err: 0, exp_first: 0,   exp_last: 448};
        tbl[1] = '{ro: 22, co: 6, mode: 0, again_at: -1, exp_err: 0, exp_first: 776, exp_last: 1224};
        tbl[2] = '{ro: 5,  co: 3, mode: 1, again_at: -1, exp_err: 0, exp_first: 178, exp_last: 626};
        tbl[3] = '{ro: 10, co: 2, mode: 0, again_at: 50, exp_err: 0, exp_first: 352, exp_last: 800};
`ifdef SCHED_BOUNDS_CHECK_EN
        tbl[4] = '{ro: 23, co: 0, mode: 0, again_at: -1, exp_err: 1, exp_first: 0,   exp_last: 0};
`else
        tbl[4] = '{ro: 23, co: 0, mode: 0, again_at: -1, exp_err: 0, exp_first: 805, exp_last: 1253};
`endif
        tbl[5] = '{ro: 0,  co: 6, mode: 1, again_at: -1, exp_err: 0, exp_first: 6,   exp_last: 454};
        tbl[6] = '{ro: 3,  co: 4, mode: 2, again_at: -1, exp_err: 0, exp_first: 109, exp_last: 557};

        rst_i = 1'b1; start_i = 1'b0; row_off_i = '0; col_off_i = '0; sched_ready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        #1;
        chk_all_zero("reset");
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i); #1;
        chk("idle_busy", 32'(busy_o), 32'd0);
        chk("idle_valid", 32'(sched_valid_o), 32'd0);

        for (int i = 0; i < 7; i++) begin
            run_frame(tbl[i].ro, tbl[i].co, tbl[i].mode, tbl[i].again_at, 0,
                      tbl[i].exp_err, tbl[i].exp_first, tbl[i].exp_last);
            repeat (2) @(negedge clk_i);
        end

        // Abort at element 100, then a fresh frame with random back-pressure.
        run_frame(0, 0, 0, -1, 100, 1'b0, 0, 448);
        run_frame(0, 0, 1, -1, 0, 1'b0, 0, 448);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mqcr_rect_scheduler.md
MQCR_RECT_SCHEDULER -- requirements
Module: mqcr_rect_scheduler

Interface
REQ-001 SHALL have parameters (name, default, meaning): IMG_W, 35, accumulator image width.
REQ-002 SHALL have parameter IMG_H, 35, accumulator image height.
REQ-003 SHALL have parameter REC_IMG_W, 29, extracted rectangle width.
REQ-004 SHALL have parameter REC_IMG_H, 13, extracted rectangle height.
REQ-005 SHALL have parameter ACC_ADDRWIDE, 11, accumulator read-address width; FEATURE_MAP_RESOLUTION and FEATURE_MAP_ADDRWIDE SHALL come from pkg_parameters.
REQ-006 SHALL have ports (name, direction, width, meaning), clock and reset first: clk_i, in, 1, single clock; rst_i, in, 1, asynchronous active-high reset.
REQ-007 start_i, in, 1, frame start request; row_off_i / col_off_i, in, 6 each, rectangle origin, sampled with start_i.
REQ-008 busy_o, out, 1, frame in progress; done_o, out, 1, one-cycle frame-complete pulse; err_o, out, 1, one-cycle rejected-start pulse.
REQ-009 acc_rd_en_o, out, 1, accumulator read strobe; acc_rd_addr_o, out, ACC_ADDRWIDE, read address; acc_rd_data_i, in, 2*FEATURE_MAP_RESOLUTION signed, read data valid exactly one cycle after acc_rd_en_o.
REQ-010 sched_valid_o, out, 1; sched_data_o, out, 2*FEATURE_MAP_RESOLUTION signed; sched_addr_o, out, FEATURE_MAP_ADDRWIDE; sched_ready_i, in, 1 -- valid/ready stream to the quantizer.

Function
REQ-011 FSM states IDLE, RUN, DRAIN, DONE; IDLE->RUN on start_i accepted; RUN->DRAIN after last read issued; DRAIN->DONE after last stream handshake; DONE->IDLE unconditionally after one cycle.
REQ-012 start_i SHALL be honoured only in IDLE; ignored in RUN, DRAIN, DONE.
REQ-013 Traversal row-major, r in 0..REC_IMG_H-1, c in 0..REC_IMG_W-1; 377 elements at defaults.
REQ-014 acc_rd_addr_o SHALL equal (row_off+r)*IMG_W + (col_off+c), origin latched at start.
REQ-015 sched_addr_o SHALL equal r*REC_IMG_W + c of the element presented; first 0, last 376 at defaults.
REQ-016 Read data SHALL be captured into a 2-entry output buffer; sched_data_o/sched_addr_o SHALL be the buffer head, registered (no combinational path from acc_rd_data_i).
REQ-017 A read SHALL issue in a cycle only if occupancy + reads in flight - pop this cycle <= 1; buffer SHALL never overflow.
REQ-018 First read SHALL issue the cycle after start_i is sampled (cycle 1); sched_valid_o SHALL rise at cycle 3; with sched_ready_i held high, throughput one element per cycle.
REQ-019 While sched_valid_o=1 and sched_ready_i=0, sched_data_o and sched_addr_o SHALL hold stable.
REQ-020 Handshake occurs when sched_valid_o and sched_ready_i both high; simultaneous push and pop SHALL keep occupancy unchanged.
REQ-021 busy_o SHALL be high in RUN and DRAIN only; done_o SHALL be high only in DONE (cycle after final handshake).
REQ-022 acc_rd_en_o SHALL be low outside RUN.

Reset
REQ-023 On rst_i: state IDLE, buffer empty, counters and latched origin zero, all outputs 0.
REQ-024 Reset mid-frame SHALL abort immediately; no done_o, no further reads or handshakes; a discarded in-flight read SHALL not appear after reset.

Configuration
REQ-025 Macro SCHED_BOUNDS_CHECK_EN defined: start_i with row_off_i > IMG_H-REC_IMG_H or col_off_i > IMG_W-REC_IMG_W SHALL pulse err_o for one cycle next cycle and remain IDLE.
REQ-026 Macro SCHED_BOUNDS_CHECK_EN undefined: no range check, err_o tied 0, all starts accepted, addresses computed per REQ-014 unmodified.

Verification
REQ-027 start_i with offsets (0,0), ready always high -> first read addr 0 at cycle 1, sched_valid_o at cycle 3, 377 handshakes addr 0..376, last acc addr 12*35+28=448, done_o one cycle.
REQ-028 offsets (22,6), ready high -> first acc addr 22*35+6=776, last 34*35+34=1224; data matches memory model.
REQ-029 ready toggled 1-of-3 random -> output stable while stalled, no loss/duplication, buffer occupancy <=2, 377 handshakes.
REQ-030 start_i pulsed during RUN -> ignored, single done_o.
REQ-031 rst_i asserted at element 100 -> all outputs 0 next cycle, no done_o; fresh start_i runs full frame correctly.
REQ-032 SCHED_BOUNDS_CHECK_EN defined, offsets (23,0) -> err_o one cycle, busy_o stays 0, no reads; undefined -> frame runs, err_o 0.
